// File: rtl/acc_frame.sv
// acc_frame: frame accumulator summing FRAME_LEN operands per result; define ACC_FRAME_SATURATE_EN to saturate instead of wrap
module acc_frame #(
  parameter int WIDTH = 8,
  parameter int FRAME_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [7:0]       out_count
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  localparam logic [7:0] FL = 8'(FRAME_LEN);
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic cout_q, cout_d;
  logic [7:0] count_q, count_d;
  logic [WIDTH:0] sum;
  logic in_xfer, out_xfer;
  assign in_ready  = state_q != HOLD;
  assign out_valid = state_q == HOLD;
  assign out_sum   = acc_q;
  assign out_cout  = cout_q;
  assign out_count = count_q;
  // next state and datapath; clear wins over any handshake
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cout_d   = cout_q;
    count_d  = count_q;
    sum      = {1'b0, acc_q} + {1'b0, in_data};
    in_xfer  = in_valid && in_ready;
    out_xfer = out_valid && out_ready;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cout_d  = 1'b0;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: if (in_xfer) begin
          acc_d   = in_data;
          cout_d  = 1'b0;
          count_d = 8'd1;
          state_d = (FL == 8'd1) ? HOLD : ACCUM;
        end
        ACCUM: if (in_xfer) begin
`ifdef ACC_FRAME_SATURATE_EN
          acc_d = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
          acc_d = sum[WIDTH-1:0];
`endif
          cout_d  = cout_q | sum[WIDTH];
          count_d = count_q + 8'd1;
          state_d = (count_q + 8'd1 == FL) ? HOLD : ACCUM;
        end
        HOLD: if (out_xfer) begin
          state_d = IDLE;
          acc_d   = '0;
          cout_d  = 1'b0;
          count_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cout_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cout_q  <= cout_d;
      count_q <= count_d;
    end
  end
endmodule

// File: doc/acc_frame.md
ACC_FRAME -- requirements
Module: acc_frame

Interface
REQ-001 Parameter WIDTH, default 8, operand and sum width in bits (legal 2..32).
REQ-002 Parameter FRAME_LEN, default 4, operands summed per frame (legal 1..255).
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 clear  input  1  synchronous frame abort, active-high.
REQ-006 in_valid  input  1  in_data holds an operand.
REQ-007 in_ready  output  1  block accepts an operand this cycle.
REQ-008 in_data  input  WIDTH  unsigned operand.
REQ-009 out_valid  output  1  out_sum/out_cout hold a completed frame result.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 out_sum  output  WIDTH  frame sum.
REQ-012 out_cout  output  1  sticky carry-out: some addition in the frame overflowed WIDTH bits.
REQ-013 out_count  output  8  operands accepted in the current frame.

Function
REQ-014 Input transfer occurs when in_valid && in_ready at a rising edge; output transfer when out_valid && out_ready.
REQ-015 FSM states IDLE, ACCUM, HOLD; encoding implementer's choice.
REQ-016 IDLE: in_ready=1, out_valid=0, accumulator 0, count 0.
REQ-017 IDLE + input transfer: acc<=in_data, count<=1, cout<=0; next state ACCUM, or HOLD if FRAME_LEN==1.
REQ-018 ACCUM: in_ready=1; on transfer acc<=acc+in_data (WIDTH+1-bit add), cout<=cout | carry, count<=count+1.
REQ-019 ACCUM -> HOLD on the transfer that makes count equal FRAME_LEN; no transfer holds state and all registers.
REQ-020 HOLD: in_ready=0, out_valid=1; out_sum, out_cout, out_count stable until output transfer.
REQ-021 HOLD + output transfer -> IDLE with accumulator, count, cout cleared; the next operand can be accepted the following cycle.
REQ-022 Latency: out_valid asserts the cycle immediately after the FRAME_LEN-th input transfer.
REQ-023 Sum wraps modulo 2^WIDTH unless REQ-030 applies.
REQ-024 in_valid gaps in ACCUM are legal and do not affect the result.
REQ-025 clear=1 in any state: next state IDLE, accumulator/count/cout zero; any simultaneous input or output transfer is discarded (in_ready and out_valid still show their state-based values that cycle).
REQ-026 Outputs are registered or decoded from state only; no combinational path from in_valid or out_ready to any output.

Reset
REQ-027 rst==0 at a rising edge forces IDLE, out_sum=0, out_cout=0, out_count=0, out_valid=0, in_ready=1 on the following cycle, regardless of state.
REQ-028 rst has priority over clear and all handshakes; reset mid-frame discards partial sum.
REQ-029 No asynchronous reset path exists.

Configuration
REQ-030 Macro ACC_FRAME_SATURATE_EN: when defined, an addition with carry sets acc to all-ones and later additions keep it all-ones; out_cout still set.
REQ-031 ACC_FRAME_SATURATE_EN undefined: wrap-around per REQ-023; interface identical in both builds.

Verification (WIDTH=8, FRAME_LEN=4)
REQ-032 Operands 1,2,3,4 back-to-back, out_ready=1 -> out_valid one cycle after 4th accept, out_sum=10, out_cout=0, out_count=4.
REQ-033 Operands 200,100,0,0 -> out_sum=44, out_cout=1; with ACC_FRAME_SATURATE_EN out_sum=255, out_cout=1.
REQ-034 Full frame, out_ready held 0 for 5 cycles -> out_valid=1, in_ready=0, outputs constant; out_ready=1 -> IDLE next cycle.
REQ-035 Operands 5,6 then rst=0 one cycle -> all outputs zero; next frame 1,1,1,1 -> out_sum=4.
REQ-036 Operands 7,7 then clear=1 with in_valid=1, in_data=9 -> 9 discarded, out_count=0; next frame 2,2,2,2 -> out_sum=8.
REQ-037 Operands 1,2,3,4 with one idle in_valid=0 cycle between each -> out_sum=10, out_cout=0.
